// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier: FSM state encoding,
// operand/count sizes and the ALU operation codes seen by the datapath.
package booth_pkg;

    localparam int BOOTH_N  = 16;
    localparam int BOOTH_CW = 5;

    localparam logic OP_ADD = 1'b1;
    localparam logic OP_SUB = 1'b0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        SHIFT = 3'd5,
        DONE  = 3'd6
    } state_e;

endpackage

// File: rtl/booth_ctrl_fsm.sv
// Moore control FSM for the radix-2 Booth multiplier (counter, A/Q/M strobes).
// Optional macro BOOTH_CYCLE_CNT_EN adds a cycles[7:0] operation-length output.
module booth_ctrl_fsm
    import booth_pkg::*;
#(
    parameter int N  = BOOTH_N,
    parameter int CW = BOOTH_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          q0,
    input  logic          qm1,
    input  logic [CW-1:0] cnt,
    output logic          ldcnt,
    output logic          dcr,
    output logic          ldM,
    output logic          ldQ,
    output logic          clrA,
    output logic          clrQm1,
    output logic          ldA,
    output logic          addsub,
    output logic          sft,
    output logic          ready,
    output logic          busy,
    output logic          done
`ifdef BOOTH_CYCLE_CNT_EN
    ,
    output logic [7:0]    cycles
`endif
);

    // The counter must be able to hold the load value N.
    if ((2 ** CW) <= N) begin : g_cw_check
        $error("booth_ctrl_fsm: CW too small for N");
    end

    state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = start ? LOAD : IDLE;
            LOAD:    state_d = CHECK;
            CHECK: begin
                // A zero count means nothing left to do, whatever the Q bits say.
                if (cnt == '0) begin
                    state_d = DONE;
                end else begin
                    case ({q0, qm1})
                        2'b10:   state_d = SUB;
                        2'b01:   state_d = ADD;
                        default: state_d = SHIFT;
                    endcase
                end
            end
            ADD:     state_d = SHIFT;
            SUB:     state_d = SHIFT;
            // cnt is still the pre-decrement value, so 1 means last iteration.
            SHIFT:   state_d = (cnt == CW'(1)) ? DONE : CHECK;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ldcnt  = 1'b0;
        dcr    = 1'b0;
        ldM    = 1'b0;
        ldQ    = 1'b0;
        clrA   = 1'b0;
        clrQm1 = 1'b0;
        ldA    = 1'b0;
        addsub = OP_SUB;
        sft    = 1'b0;
        ready  = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        case (state_q)
            IDLE: ready = 1'b1;
            LOAD: begin
                ldM    = 1'b1;
                ldQ    = 1'b1;
                clrA   = 1'b1;
                clrQm1 = 1'b1;
                ldcnt  = 1'b1;
                busy   = 1'b1;
            end
            CHECK: busy = 1'b1;
            ADD: begin
                ldA    = 1'b1;
                addsub = OP_ADD;
                busy   = 1'b1;
            end
            SUB: begin
                ldA    = 1'b1;
                addsub = OP_SUB;
                busy   = 1'b1;
            end
            SHIFT: begin
                sft  = 1'b1;
                dcr  = 1'b1;
                busy = 1'b1;
            end
            DONE: done = 1'b1;
            default: ;
        endcase
    end

`ifdef BOOTH_CYCLE_CNT_EN
    logic [7:0] cyc_q, cyc_d;

    // LOAD counts as the first cycle; DONE and IDLE hold the final length.
    always_comb begin
        cyc_d = cyc_q;
        case (state_q)
            LOAD:                     cyc_d = 8'd1;
            CHECK, ADD, SUB, SHIFT:   cyc_d = cyc_q + 8'd1;
            default:                  cyc_d = cyc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cyc_q <= 8'd0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign cycles = cyc_q;
`endif

endmodule

// File: tb/tb_booth_ctrl_fsm.sv
// Directed bench for booth_ctrl_fsm with a behavioural counter and A/Q/M datapath.
// Checks BOOTH_CYCLE_CNT_EN behaviour when that macro is defined.
module tb_booth_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst_n, start, q0, qm1;
    logic [4:0]  cnt, cnt_m;
    logic        cnt_force;
    logic        ldcnt, dcr, ldM, ldQ, clrA, clrQm1, ldA, addsub, sft, ready, busy, done;
`ifdef BOOTH_CYCLE_CNT_EN
    logic [7:0]  cycles;
`endif

    logic [15:0] A, Q, M, m_in, q_in;
    logic        Qm1;
    int          total = 0;
    int          bad   = 0;

    int          n_lda = 0, n_sft = 0, n_viol = 0;
    logic [31:0] lda_hist = '0;

    always #5 clk = ~clk;

    booth_ctrl_fsm dut (
        .clk(clk), .rst_n(rst_n), .start(start), .q0(q0), .qm1(qm1), .cnt(cnt),
        .ldcnt(ldcnt), .dcr(dcr), .ldM(ldM), .ldQ(ldQ), .clrA(clrA), .clrQm1(clrQm1),
        .ldA(ldA), .addsub(addsub), .sft(sft), .ready(ready), .busy(busy), .done(done)
`ifdef BOOTH_CYCLE_CNT_EN
        , .cycles(cycles)
`endif
    );

    assign q0  = Q[0];
    assign qm1 = Qm1;
    assign cnt = cnt_force ? 5'd0 : cnt_m;

    // Environment: iteration counter and Booth datapath driven by the strobes.
    always_ff @(posedge clk) begin
        if (ldcnt) cnt_m <= 5'd16;
        else if (dcr) cnt_m <= cnt_m - 5'd1;
        if (ldM) M <= m_in;
        if (ldQ) Q <= q_in;
        if (clrA) A <= '0;
        if (clrQm1) Qm1 <= 1'b0;
        if (ldA) A <= addsub ? (A + M) : (A - M);
        if (sft) {A, Q, Qm1} <= {A[15], A, Q};
    end

    always @(negedge clk) begin
        if (ldA) begin
            n_lda    <= n_lda + 1;
            lda_hist <= {lda_hist[30:0], addsub};
        end
        if (sft) n_sft <= n_sft + 1;
        if ((ldA && sft) || (ldcnt && dcr)) n_viol <= n_viol + 1;
    end

    // Starts an operation from IDLE; returns at the negedge where done=1.
    // lat counts cycles with the LOAD cycle as 1; -1 on timeout.
    task automatic run_op(input logic [15:0] mv, input logic [15:0] qv,
                          input bit hold, output int lat);
        int w;
        @(negedge clk);
        w = 0;
        while (!ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        m_in  = mv;
        q_in  = qv;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        lat = 1;
        forever begin
            @(negedge clk);
            if (done) break;
            if (lat > 100) begin
                lat = -1;
                break;
            end
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: got %b want 1", ready);
        end
        total++;
        if ({ldcnt, dcr, ldM, ldQ, clrA, clrQm1, ldA, addsub, sft, busy, done} !== 11'b0) begin
            bad++;
            $display("FAIL reset_strobes: got %b want 0",
                     {ldcnt, dcr, ldM, ldQ, clrA, clrQm1, ldA, addsub, sft, busy, done});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_zero();
        int lat, l0, s0, v0;
        l0 = n_lda; s0 = n_sft; v0 = n_viol;
        run_op(16'd3, 16'h0000, 1'b0, lat);
        total++;
        if (lat !== 34) begin bad++; $display("FAIL zero_latency: got %0d want 34", lat); end
        total++;
        if (n_lda - l0 !== 0) begin bad++; $display("FAIL zero_ldA: got %0d want 0", n_lda - l0); end
        total++;
        if (n_sft - s0 !== 16) begin bad++; $display("FAIL zero_shifts: got %0d want 16", n_sft - s0); end
        total++;
        if ({A, Q} !== 32'h0) begin bad++; $display("FAIL zero_product: got %h want 00000000", {A, Q}); end
        total++;
        if (n_viol !== v0) begin bad++; $display("FAIL zero_exclusive: got %0d want %0d", n_viol, v0); end
`ifdef BOOTH_CYCLE_CNT_EN
        total++;
        if (cycles !== 8'd33) begin bad++; $display("FAIL cycles_done: got %0d want 33", cycles); end
        repeat (3) @(negedge clk);
        total++;
        if (cycles !== 8'd33) begin bad++; $display("FAIL cycles_idle: got %0d want 33", cycles); end
`endif
    endtask

    task automatic test_ffff();
        int lat, l0;
        l0 = n_lda;
        run_op(16'd3, 16'hFFFF, 1'b0, lat);
        total++;
        if (lat !== 35) begin bad++; $display("FAIL ffff_latency: got %0d want 35", lat); end
        total++;
        if (n_lda - l0 !== 1) begin bad++; $display("FAIL ffff_ldA: got %0d want 1", n_lda - l0); end
        total++;
        if ({A, Q} !== 32'hFFFFFFFD) begin bad++; $display("FAIL ffff_product: got %h want FFFFFFFD", {A, Q}); end
    endtask

    task automatic test_alt();
        int lat, l0, v0;
        l0 = n_lda; v0 = n_viol;
        run_op(16'd3, 16'h5555, 1'b0, lat);
        total++;
        if (lat !== 50) begin bad++; $display("FAIL alt_latency: got %0d want 50", lat); end
        total++;
        if (n_lda - l0 !== 16) begin bad++; $display("FAIL alt_ldA: got %0d want 16", n_lda - l0); end
        total++;
        if (lda_hist[15:0] !== 16'h5555) begin bad++; $display("FAIL alt_addsub_seq: got %h want 5555", lda_hist[15:0]); end
        total++;
        if ({A, Q} !== 32'h0000FFFF) begin bad++; $display("FAIL alt_product: got %h want 0000FFFF", {A, Q}); end
        total++;
        if (n_viol !== v0) begin bad++; $display("FAIL alt_exclusive: got %0d want %0d", n_viol, v0); end
    endtask

    task automatic test_reset_mid_sub();
        int lat;
        @(negedge clk);
        m_in = 16'd3; q_in = 16'hFFFF; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;   // LOAD
        @(posedge clk);                      // CHECK
        @(posedge clk);                      // SUB
        @(negedge clk);
        total++;
        if (ldA !== 1'b1 || addsub !== 1'b0) begin
            bad++; $display("FAIL midsub_in_sub: got ldA=%b addsub=%b want 1 0", ldA, addsub);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        total++;
        if (ready !== 1'b1 || {ldcnt, dcr, ldM, ldQ, clrA, clrQm1, ldA, sft, busy, done} !== 10'b0) begin
            bad++; $display("FAIL midsub_idle: got ready=%b strobes=%b want 1 0", ready,
                            {ldcnt, dcr, ldM, ldQ, clrA, clrQm1, ldA, sft, busy, done});
        end
        run_op(16'd3, 16'hFFFF, 1'b0, lat);
        total++;
        if (lat !== 35 || {A, Q} !== 32'hFFFFFFFD) begin
            bad++; $display("FAIL midsub_rerun: got lat=%0d prod=%h want 35 FFFFFFFD", lat, {A, Q});
        end
    endtask

    task automatic test_start_held();
        int lat, w;
        run_op(16'd3, 16'h0000, 1'b1, lat);
        total++;
        if (lat !== 34) begin bad++; $display("FAIL held_latency: got %0d want 34", lat); end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || ready !== 1'b1) begin
            bad++; $display("FAIL held_idle: got done=%b ready=%b want 0 1", done, ready);
        end
        @(negedge clk);
        total++;
        if (ldcnt !== 1'b1 || ldM !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL held_reload: got ldcnt=%b ldM=%b busy=%b want 1 1 1", ldcnt, ldM, busy);
        end
        start = 1'b0;
        w = 0;
        while (!done && w < 100) begin
            @(negedge clk);
            w++;
        end
        total++;
        if (w !== 33) begin bad++; $display("FAIL held_second_done: got %0d want 33", w); end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL held_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_cnt_zero();
        @(negedge clk);
        m_in = 16'd3; q_in = 16'h0000; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;   // LOAD
        @(posedge clk); #1;                  // CHECK
        cnt_force = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b1 || sft !== 1'b0) begin
            bad++; $display("FAIL cnt0_check: got busy=%b sft=%b want 1 0", busy, sft);
        end
        @(posedge clk); #1;
        cnt_force = 1'b0;
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL cnt0_done: got %b want 1", done); end
        @(negedge clk);
        @(negedge clk);
        total++;
        if (ready !== 1'b1) begin bad++; $display("FAIL cnt0_idle: got %b want 1", ready); end
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; cnt_force = 1'b0;
        m_in = '0; q_in = '0;
        test_reset();
        test_zero();
        test_ffff();
        test_alt();
        test_reset_mid_sub();
        test_start_held();
        test_cnt_zero();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
